// File: rtl/qoi_bus_arbiter.sv
// qoi_bus_arbiter: shares one synchronous memory port between the 65c02 and the QOI DMA.
// Define QOI_ARB_STATS_EN to add the stall_cnt/stall_clr statistics ports.
module qoi_bus_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CPU_SLOTS = 2,
    parameter logic [15:0] WIN_LO    = 16'h8000,
    parameter logic [15:0] WIN_HI    = 16'h9FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic        dma_err,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
`ifdef QOI_ARB_STATS_EN
    input  logic        stall_clr,
    output logic [15:0] stall_cnt,
`endif
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_DMA  = 2'd1,
        S_COOL = 2'd2
    } state_t;

    localparam logic [7:0] BLAST = 8'(MAX_BURST - 1);
    localparam logic [7:0] CLAST = 8'(CPU_SLOTS - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] bcnt;
    logic [7:0] ccnt;
    logic       own_dma;
    logic       acc;
    logic       in_win;
    logic       prev_cpu;
    logic [7:0] hold;

    assign own_dma = (state == S_DMA);
    assign acc     = own_dma & dma_req;
    assign in_win  = (dma_addr >= WIN_LO) && (dma_addr <= WIN_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_CPU;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_CPU: begin
                if (dma_req) state_n = S_DMA;
            end
            S_DMA: begin
                if (!dma_req) begin
                    state_n = S_CPU;
                end else if (bcnt == BLAST) begin
                    state_n = S_COOL;
                end
            end
            S_COOL: begin
                if (ccnt == CLAST) begin
                    state_n = dma_req ? S_DMA : S_CPU;
                end
            end
            default: state_n = S_CPU;
        endcase
    end

    always_comb begin
        cpu_rdy   = !own_dma;
        dma_gnt   = own_dma;
        mem_addr  = cpu_ab;
        mem_wdata = cpu_do;
        mem_we    = cpu_we;
        if (own_dma) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            // dropped requests and fenced addresses never reach memory
            mem_we    = acc & dma_we & in_win;
        end
    end

    // burst and cool-down counters fall back to zero whenever their phase ends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt <= 8'd0;
            ccnt <= 8'd0;
        end else begin
            bcnt <= (acc && bcnt != BLAST) ? bcnt + 8'd1 : 8'd0;
            ccnt <= (state == S_COOL && ccnt != CLAST) ? ccnt + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_cpu   <= 1'b0;
            hold       <= 8'hEA;
            dma_rvalid <= 1'b0;
            dma_err    <= 1'b0;
        end else begin
            prev_cpu   <= !own_dma;
            if (prev_cpu) hold <= mem_rdata;
            dma_rvalid <= acc & !dma_we & in_win;
            dma_err    <= acc & !in_win;
        end
    end

    assign cpu_di    = prev_cpu ? mem_rdata : hold;
    assign dma_rdata = mem_rdata;

`ifdef QOI_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (stall_clr) begin
            stall_cnt <= 16'd0;
        end else if (own_dma && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
